// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, default VGA timing and colour-bar helper for display_timing
package display_pkg;

    localparam int COORD_W = 10;

    typedef logic [11:0]        rgb444_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t h_active;
        coord_t h_fp;
        coord_t h_sync;
        coord_t h_bp;
        coord_t v_active;
        coord_t v_fp;
        coord_t v_sync;
        coord_t v_bp;
        logic   hsync_pol;
        logic   vsync_pol;
    } display_timing_t;

    localparam display_timing_t VGA_640x480_60 = '{
        h_active : 10'd640, h_fp : 10'd16, h_sync : 10'd96, h_bp : 10'd48,
        v_active : 10'd480, v_fp : 10'd10, v_sync : 10'd2,  v_bp : 10'd33,
        hsync_pol : 1'b0,   vsync_pol : 1'b0
    };

    // One raster beat as it travels from the fetch stage to the display stage.
    typedef struct packed {
        logic    hsync;
        logic    vsync;
        logic    de;
        coord_t  x;
        coord_t  y;
        logic    frame_start;
        logic    line_start;
        rgb444_t rgb;
    } pixel_beat_t;

    function automatic rgb444_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

endpackage

// File: rtl/display_timing_if.sv
// rtl/display_timing_if.sv - raster timing and pixel-fetch bundle between display_timing and its consumers
interface display_timing_if;
    import display_pkg::*;

    logic    hsync;
    logic    vsync;
    logic    de;
    coord_t  pixel_x;
    coord_t  pixel_y;
    logic    frame_start;
    logic    line_start;
    logic    fetch_valid;
    coord_t  fetch_x;
    coord_t  fetch_y;
    rgb444_t rgb_out;

    modport master (
        output hsync, vsync, de, pixel_x, pixel_y, frame_start, line_start,
        output fetch_valid, fetch_x, fetch_y, rgb_out
    );

    modport slave (
        input hsync, vsync, de, pixel_x, pixel_y, frame_start, line_start,
        input fetch_valid, fetch_x, fetch_y, rgb_out
    );

endinterface

// File: rtl/display_timing_counter.sv
// rtl/display_timing_counter.sv - wrap counter 0..MAX advancing on incr, wrap flags the MAX->0 step
module display_timing_counter
    import display_pkg::*;
#(
    parameter int MAX = 799
) (
    input  logic   clk_display,
    input  logic   reset,
    input  logic   incr,
    output logic   wrap,
    output coord_t count
);

    localparam coord_t MAX_C = coord_t'(MAX);

    coord_t count_q;
    coord_t count_d;

    always_comb begin
        wrap    = incr && (count_q == MAX_C);
        count_d = count_q;
        if (incr) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_display) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/display_timing.sv
// rtl/display_timing.sv - raster timing generator with pixel fetch leading data-enable by FETCH_LEAD cycles
// Optional colour-bar test pattern on rgb_out: DISPLAY_TIMING_TEST_PATTERN_EN.
module display_timing
    import display_pkg::*;
#(
    parameter display_timing_t TIMING     = VGA_640x480_60,
    parameter int              FETCH_LEAD = 2
) (
    input  logic             clk_display,
    input  logic             reset,
    display_timing_if.master vid
);

    localparam int H_ACTIVE = int'(TIMING.h_active);
    localparam int H_FP     = int'(TIMING.h_fp);
    localparam int H_SYNC   = int'(TIMING.h_sync);
    localparam int H_BP     = int'(TIMING.h_bp);
    localparam int V_ACTIVE = int'(TIMING.v_active);
    localparam int V_FP     = int'(TIMING.v_fp);
    localparam int V_SYNC   = int'(TIMING.v_sync);
    localparam int V_BP     = int'(TIMING.v_bp);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $fatal(1, "display_timing: timing parameters must be non-zero");
    end
    if (FETCH_LEAD < 0 || FETCH_LEAD > 8) begin : g_bad_lead
        $fatal(1, "display_timing: FETCH_LEAD must be 0..8");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $fatal(1, "display_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    // Back porches are non-zero, so every sync bound stays below 1024 and fits a coord_t.
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam pixel_beat_t RESET_BEAT = '{
        hsync   : ~TIMING.hsync_pol,
        vsync   : ~TIMING.vsync_pol,
        default : '0
    };

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap_unused;

    display_timing_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
        .clk_display (clk_display),
        .reset       (reset),
        .incr        (1'b1),
        .wrap        (h_wrap),
        .count       (h_cnt)
    );

    display_timing_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
        .clk_display (clk_display),
        .reset       (reset),
        .incr        (h_wrap),
        .wrap        (v_wrap_unused),
        .count       (v_cnt)
    );

    logic    active;
    rgb444_t pattern_rgb;

`ifdef DISPLAY_TIMING_TEST_PATTERN_EN
    localparam int     BAR_W      = H_ACTIVE / 8;
    localparam int     BAR_W_SAFE = (BAR_W == 0) ? 1 : BAR_W;
    localparam coord_t BARS_END   = coord_t'(8 * BAR_W);

    always_comb begin
        pattern_rgb = '0;
        if (h_cnt < BARS_END) begin
            pattern_rgb = bar_colour(3'(h_cnt / coord_t'(BAR_W_SAFE)));
        end
    end
`else
    assign pattern_rgb = '0;
`endif

    pixel_beat_t fetch_q;
    pixel_beat_t fetch_d;

    always_comb begin
        active              = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        fetch_d             = RESET_BEAT;
        fetch_d.hsync       = (h_cnt >= HS_START && h_cnt < HS_END) ?
                              TIMING.hsync_pol : ~TIMING.hsync_pol;
        fetch_d.vsync       = (v_cnt >= VS_START && v_cnt < VS_END) ?
                              TIMING.vsync_pol : ~TIMING.vsync_pol;
        fetch_d.de          = active;
        fetch_d.x           = active ? h_cnt : '0;
        fetch_d.y           = active ? v_cnt : '0;
        fetch_d.frame_start = active && (h_cnt == '0) && (v_cnt == '0);
        fetch_d.line_start  = active && (h_cnt == '0);
        fetch_d.rgb         = active ? pattern_rgb : '0;
    end

    always_ff @(posedge clk_display) begin
        if (reset) begin
            fetch_q <= RESET_BEAT;
        end else begin
            fetch_q <= fetch_d;
        end
    end

    pixel_beat_t disp_beat;

    // The display stage replays the fetch stage FETCH_LEAD cycles later, so every output moves together.
    if (FETCH_LEAD == 0) begin : g_no_lead
        assign disp_beat = fetch_q;
    end else begin : g_lead
        pixel_beat_t pipe_q [FETCH_LEAD];
        pixel_beat_t pipe_d [FETCH_LEAD];

        always_comb begin
            pipe_d[0] = fetch_q;
            for (int i = 1; i < FETCH_LEAD; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk_display) begin
            if (reset) begin
                for (int i = 0; i < FETCH_LEAD; i++) begin
                    pipe_q[i] <= RESET_BEAT;
                end
            end else begin
                for (int i = 0; i < FETCH_LEAD; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign disp_beat = pipe_q[FETCH_LEAD-1];
    end

    assign vid.fetch_valid = fetch_q.de;
    assign vid.fetch_x     = fetch_q.x;
    assign vid.fetch_y     = fetch_q.y;
    assign vid.hsync       = disp_beat.hsync;
    assign vid.vsync       = disp_beat.vsync;
    assign vid.de          = disp_beat.de;
    assign vid.pixel_x     = disp_beat.x;
    assign vid.pixel_y     = disp_beat.y;
    assign vid.frame_start = disp_beat.frame_start;
    assign vid.line_start  = disp_beat.line_start;
    assign vid.rgb_out     = disp_beat.rgb;

endmodule
